// File: rtl/fp_mul_normround.sv
// Post-multiply normalise / round / pack stage of the binary32 multiplier.
// Turns a raw 48-bit significand product into a packed result over a REQ/ACK handshake.
module fp_mul_normround (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        SIGN,
    input  logic [7:0]  EXP1,
    input  logic [7:0]  EXP2,
    input  logic [48:0] PROD,
    output logic        ACK,
    output logic [31:0] DATAOUT,
    output logic [2:0]  EXC
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NORM  = 3'd1;
    localparam logic [2:0] ST_ROUND = 3'd2;
    localparam logic [2:0] ST_PACK  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] EXC_NORMAL = 3'b000;
    localparam logic [2:0] EXC_ZERO   = 3'b001;
    localparam logic [2:0] EXC_UNDER  = 3'b010;
    localparam logic [2:0] EXC_OVER   = 3'b100;

    // Round-to-nearest-even increment decision from guard, sticky and LSB.
    function automatic logic f_round_inc(input logic g, input logic s, input logic lsb);
        f_round_inc = g & (s | lsb);
    endfunction

    // Unbiased-sum exponent in 10-bit two's complement; never wraps for 8-bit inputs.
    function automatic logic [9:0] f_exp_sum(input logic [7:0] e1, input logic [7:0] e2,
                                             input logic top_set);
        logic [9:0] bias;
        bias      = top_set ? 10'd126 : 10'd127;
        f_exp_sum = {2'b00, e1} + {2'b00, e2} - bias;
    endfunction

    logic [2:0]  r_state;
    logic        r_sign;
    logic [7:0]  r_exp1;
    logic [7:0]  r_exp2;
    logic [47:0] r_prod;
    logic [9:0]  r_exp;
    logic [23:0] r_mant;
    logic        r_g;
    logic        r_s;
    logic        r_ack;
    logic [31:0] r_dataout;
    logic [2:0]  r_exc;

    logic [2:0]  w_state_nxt;
    logic [9:0]  w_norm_exp;
    logic [23:0] w_norm_mant;
    logic        w_norm_g;
    logic        w_norm_s;
    logic [24:0] w_rnd_m25;
    logic [23:0] w_rnd_mant;
    logic [9:0]  w_rnd_exp;
    logic        w_exp_ovf;
    logic        w_exp_udf;
    logic [31:0] w_pack_data;
    logic [2:0]  w_pack_exc;
    logic        w_unused_prod48;

    // Bit 48 of the product is architecturally always zero.
    assign w_unused_prod48 = PROD[48];

    // Next-state logic for the handshake sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (REQ) begin
                    w_state_nxt = ST_NORM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_NORM:  w_state_nxt = ST_ROUND;
            ST_ROUND: w_state_nxt = ST_PACK;
            ST_PACK:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (REQ) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Normalisation: select the 24-bit window depending on whether the product carried into bit 47.
    always_comb begin
        w_norm_exp  = f_exp_sum(r_exp1, r_exp2, r_prod[47]);
        w_norm_mant = 24'd0;
        w_norm_g    = 1'b0;
        w_norm_s    = 1'b0;
        if (r_prod[47]) begin
            w_norm_mant = r_prod[47:24];
            w_norm_g    = r_prod[23];
            w_norm_s    = |r_prod[22:0];
        end else begin
            w_norm_mant = r_prod[46:23];
            w_norm_g    = r_prod[22];
            w_norm_s    = |r_prod[21:0];
        end
    end

    // Rounding; an all-ones mantissa that carries out renormalises to 1.0 with exponent + 1.
    always_comb begin
        w_rnd_m25  = {1'b0, r_mant} + {24'd0, f_round_inc(r_g, r_s, r_mant[0])};
        w_rnd_mant = w_rnd_m25[23:0];
        w_rnd_exp  = r_exp;
        if (w_rnd_m25[24]) begin
            w_rnd_mant = 24'h800000;
            w_rnd_exp  = r_exp + 10'd1;
        end else begin
            w_rnd_mant = w_rnd_m25[23:0];
            w_rnd_exp  = r_exp;
        end
    end

    assign w_exp_ovf = ($signed(r_exp) >= $signed(10'sd255));
    assign w_exp_udf = ($signed(r_exp) <= $signed(10'sd0));

    // Result packing with zero > overflow > underflow > normal priority.
    always_comb begin
        w_pack_data = 32'd0;
        w_pack_exc  = EXC_NORMAL;
        if (r_prod == 48'd0) begin
            w_pack_data = {r_sign, 31'd0};
            w_pack_exc  = EXC_ZERO;
        end else if (w_exp_ovf) begin
            w_pack_data = {r_sign, 8'hFF, 23'd0};
            w_pack_exc  = EXC_OVER;
        end else if (w_exp_udf) begin
            w_pack_data = {r_sign, 31'd0};
            w_pack_exc  = EXC_UNDER;
        end else begin
            w_pack_data = {r_sign, r_exp[7:0], r_mant[22:0]};
            w_pack_exc  = EXC_NORMAL;
        end
    end

    // State, datapath and output registers; reset discards any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_sign    <= 1'b0;
            r_exp1    <= 8'd0;
            r_exp2    <= 8'd0;
            r_prod    <= 48'd0;
            r_exp     <= 10'd0;
            r_mant    <= 24'd0;
            r_g       <= 1'b0;
            r_s       <= 1'b0;
            r_ack     <= 1'b0;
            r_dataout <= 32'd0;
            r_exc     <= EXC_NORMAL;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (REQ) begin
                        r_sign <= SIGN;
                        r_exp1 <= EXP1;
                        r_exp2 <= EXP2;
                        r_prod <= PROD[47:0];
                    end
                end
                ST_NORM: begin
                    r_exp  <= w_norm_exp;
                    r_mant <= w_norm_mant;
                    r_g    <= w_norm_g;
                    r_s    <= w_norm_s;
                end
                ST_ROUND: begin
                    r_exp  <= w_rnd_exp;
                    r_mant <= w_rnd_mant;
                end
                ST_PACK: begin
                    r_dataout <= w_pack_data;
                    r_exc     <= w_pack_exc;
                    r_ack     <= 1'b1;
                end
                ST_DONE: begin
                    if (!REQ) begin
                        r_ack <= 1'b0;
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign ACK     = r_ack;
    assign DATAOUT = r_dataout;
    assign EXC     = r_exc;

endmodule

// File: tb/tb_fp_mul_normround.sv
// Directed bench for fp_mul_normround: value-level rounding model plus literal vectors,
// with a per-cycle monitor on DATAOUT/EXC.
module tb_fp_mul_normround;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ;
    logic        SIGN;
    logic [7:0]  EXP1;
    logic [7:0]  EXP2;
    logic [48:0] PROD;
    logic        ACK;
    logic [31:0] DATAOUT;
    logic [2:0]  EXC;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_data  = 32'd0;
    logic [2:0]  exp_exc   = 3'd0;
    logic [31:0] hold_data = 32'd0;
    logic [2:0]  hold_exc  = 3'd0;
    bit          mon_en    = 1'b0;

    fp_mul_normround dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .SIGN    (SIGN),
        .EXP1    (EXP1),
        .EXP2    (EXP2),
        .PROD    (PROD),
        .ACK     (ACK),
        .DATAOUT (DATAOUT),
        .EXC     (EXC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Value-level model: scale, round the discarded remainder against one half, classify.
    task automatic model(input logic s, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [48:0] prod, output logic [31:0] d, output logic [2:0] x);
        logic [47:0]     p;
        int              e;
        int              sh;
        longint unsigned mant;
        longint unsigned rem;
        longint unsigned half;
        p = prod[47:0];
        if (p == 48'd0) begin
            d = {s, 31'd0};
            x = 3'b001;
            return;
        end
        e  = int'(e1) + int'(e2) - 127;
        sh = 23;
        if (p[47]) begin
            e++;
            sh = 24;
        end
        mant = {16'd0, p} >> sh;
        rem  = {16'd0, p} - (mant << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) begin
            d = {s, 8'hFF, 23'd0};
            x = 3'b100;
        end else if (e <= 0) begin
            d = {s, 31'd0};
            x = 3'b010;
        end else begin
            d = {s, e[7:0], mant[22:0]};
            x = 3'b000;
        end
    endtask

    // Monitor: result must match the expected transaction while ACK is high, otherwise hold.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ACK === 1'b1) begin
                check("dataout", DATAOUT, exp_data);
                check("exc", 32'(EXC), 32'(exp_exc));
                hold_data = exp_data;
                hold_exc  = exp_exc;
            end else begin
                check("hold_dataout", DATAOUT, hold_data);
                check("hold_exc", 32'(EXC), 32'(hold_exc));
            end
        end
    end

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        while (ACK !== 1'b1 && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'd3);
    endtask

    task automatic run_txn(input string nm, input logic s, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [48:0] prod,
                           input logic [31:0] lit_d, input logic [2:0] lit_x, input bit early);
        logic [31:0] md;
        logic [2:0]  mx;
        model(s, e1, e2, prod, md, mx);
        check({nm, " model_data"}, md, lit_d);
        check({nm, " model_exc"}, 32'(mx), 32'(lit_x));
        exp_data = lit_d;
        exp_exc  = lit_x;
        SIGN = s;
        EXP1 = e1;
        EXP2 = e2;
        PROD = prod;
        REQ  = 1'b1;
        @(posedge CLK);
        #1;
        SIGN = ~s;
        EXP1 = ~e1;
        EXP2 = ~e2;
        PROD = ~prod;
        if (early) REQ = 1'b0;
        wait_ack(nm);
        if (!early) begin
            repeat (2) begin
                @(posedge CLK);
                #1;
                check({nm, " ack_held"}, 32'(ACK), 32'd1);
            end
            REQ = 1'b0;
        end
        @(posedge CLK);
        #1;
        check({nm, " ack_drop"}, 32'(ACK), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST  = 1'b1;
        REQ  = 1'b0;
        SIGN = 1'b0;
        EXP1 = 8'd0;
        EXP2 = 8'd0;
        PROD = 49'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset ack", 32'(ACK), 32'd0);
        check("reset dataout", DATAOUT, 32'd0);
        check("reset exc", 32'(EXC), 32'd0);
        RST       = 1'b0;
        hold_data = 32'd0;
        hold_exc  = 3'd0;
        mon_en    = 1'b1;
        @(posedge CLK);
        #1;

        run_txn("mul_2p75x5p5",   1'b0, 8'd128, 8'd129, 49'h0790000000000, 32'h41720000, 3'b000, 1'b0);
        run_txn("neg_sign",       1'b1, 8'd128, 8'd129, 49'h0790000000000, 32'hC1720000, 3'b000, 1'b0);
        run_txn("top_bit_path",   1'b0, 8'd127, 8'd127, 49'h0900000000000, 32'h40100000, 3'b000, 1'b0);
        run_txn("round_carry",    1'b0, 8'd127, 8'd127, 49'h07FFFFFC00000, 32'h40000000, 3'b000, 1'b0);
        run_txn("tie_even",       1'b0, 8'd127, 8'd127, 49'h0400000400000, 32'h3F800000, 3'b000, 1'b0);
        run_txn("tie_odd_up",     1'b0, 8'd127, 8'd127, 49'h0400000C00000, 32'h3F800002, 3'b000, 1'b0);
        run_txn("overflow",       1'b0, 8'd254, 8'd254, 49'h0400000000000, 32'h7F800000, 3'b100, 1'b0);
        run_txn("underflow",      1'b0, 8'd1,   8'd1,   49'h0400000000000, 32'h00000000, 3'b010, 1'b0);
        run_txn("zero_prod",      1'b1, 8'd127, 8'd127, 49'h0000000000000, 32'h80000000, 3'b001, 1'b0);
        run_txn("exp_255_ovf",    1'b1, 8'd128, 8'd254, 49'h0400000000000, 32'hFF800000, 3'b100, 1'b0);
        run_txn("exp_254_max",    1'b0, 8'd127, 8'd254, 49'h0400000000000, 32'h7F000000, 3'b000, 1'b0);
        run_txn("exp_0_udf",      1'b0, 8'd63,  8'd64,  49'h0400000000000, 32'h00000000, 3'b010, 1'b0);
        run_txn("exp_1_min",      1'b0, 8'd64,  8'd64,  49'h0400000000000, 32'h00800000, 3'b000, 1'b0);
        run_txn("early_req_drop", 1'b0, 8'd128, 8'd129, 49'h0790000000000, 32'h41720000, 3'b000, 1'b1);

        // Reset mid-operation, then a fresh capture while REQ stays high.
        exp_data = 32'h41720000;
        exp_exc  = 3'b000;
        SIGN = 1'b0;
        EXP1 = 8'd128;
        EXP2 = 8'd129;
        PROD = 49'h0790000000000;
        REQ  = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        hold_data = 32'd0;
        hold_exc  = 3'd0;
        check("midrst ack", 32'(ACK), 32'd0);
        check("midrst dataout", DATAOUT, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_req ack", 32'(ACK), 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        wait_ack("after_rst");
        REQ = 1'b0;
        @(posedge CLK);
        #1;
        check("after_rst ack_drop", 32'(ACK), 32'd0);
        repeat (3) @(posedge CLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_normround.md
# fp_mul_normround

Post-multiply normalise/round/pack stage of the single-precision FP multiplier. Consumes the raw significand product from the Booth multiplier, the result sign and the two biased operand exponents from the multiplier controller. Produces a packed IEEE-754 binary32 result with an exception code over a four-phase REQ/ACK handshake. Operand special cases (NaN, Inf) are screened upstream by the exception checker; this block treats all operands as finite normals, except for a zero product.

## Interface
Parameters: none (binary32 fixed).

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  1  request; operands valid while high
- SIGN  in  1  result sign (sign1 XOR sign2)
- EXP1  in  8  biased exponent, operand 1
- EXP2  in  8  biased exponent, operand 2
- PROD  in  49  unsigned 24x24 significand product; bit 48 must be 0 and is ignored
- ACK  out  1  result valid / handshake acknowledge
- DATAOUT  out  32  packed result {sign, exp[7:0], frac[22:0]}
- EXC  out  3  000 normal, 001 zero, 010 underflow (flushed to zero), 100 overflow (infinity)

## Operation
- States: IDLE, NORM, ROUND, PACK, DONE. RST forces IDLE from any state.
- IDLE: if REQ=1, capture SIGN, EXP1, EXP2 and PROD[47:0], then go to NORM. The block ignores input changes after capture.
- NORM: compute exp as a 10-bit two's complement value.
  - If PROD[47]=1: mant=PROD[47:24], G=PROD[23], S=|PROD[22:0], exp=EXP1+EXP2-126.
  - Otherwise: mant=PROD[46:23], G=PROD[22], S=|PROD[21:0], exp=EXP1+EXP2-127.
  - Range is -127..384, with no wrap in 10 bits.
- ROUND: round to nearest, ties to even. inc = G & (S | mant[0]); m25 = mant + inc (25 bits).
  - If m25[24]=1: mant=24'h800000 and exp=exp+1.
  - Otherwise: mant=m25[23:0].
- PACK: the checks below apply in priority order.
  - PROD==0 → {SIGN,31'b0}, EXC=001.
  - Else exp ≥ 255 → {SIGN,8'hFF,23'b0}, EXC=100.
  - Else exp ≤ 0 → {SIGN,31'b0}, EXC=010. Subnormals are not produced.
  - Else → {SIGN, exp[7:0], mant[22:0]}, EXC=000.
- DONE: ACK=1. Stay in DONE while REQ=1. When REQ=0, go to IDLE and drop ACK.

## Timing
- Reset values: ACK=0, DATAOUT=32'h0, EXC=3'b000, state=IDLE.
- Capture at edge k, where REQ is sampled high in IDLE.
- DATAOUT and EXC are registered at edge k+3. ACK rises at edge k+3, so latency is 3 cycles.
- ACK falls on the first edge in DONE where REQ is sampled low.
- A new capture requires REQ high in IDLE, so back-to-back transactions have at least one ACK-low cycle between them.
- DATAOUT and EXC hold their last values while ACK is low. They change only at the PACK→DONE edge, or to 0 on RST.
- If REQ drops before ACK (protocol violation), the block completes anyway. ACK is high for exactly one cycle, then the block returns to IDLE.
- RST asserted mid-operation: at the next edge, outputs take reset values and the in-flight transaction is discarded. REQ still high after RST deasserts starts a fresh capture.
- RST and REQ high on the same edge: RST wins; no capture.

## Test plan
- 2.75×5.5: EXP1=128, EXP2=129, PROD=49'h0790000000000, SIGN=0 → DATAOUT=32'h41720000, EXC=000. ACK 3 cycles after capture; ACK drops one edge after REQ falls.
- Same operands with SIGN=1 → 32'hC1720000. Then PROD[47]=1 path: EXP1=EXP2=127, PROD=49'h0900000000000 → 32'h40100000 (2.25).
- Rounding:
  - Carry-out case: EXP1=EXP2=127, PROD=49'h07FFFFFC00000 → 32'h40000000 (mant renormalised, exp+1).
  - Tie-to-even, no increment: PROD=49'h0400000400000 → 32'h3F800000.
- Exceptions:
  - EXP1=EXP2=254, PROD=49'h0400000000000 → 32'h7F800000, EXC=100.
  - EXP1=EXP2=1, same PROD → 32'h00000000, EXC=010.
  - PROD=0, SIGN=1 → 32'h80000000, EXC=001.
- Reset mid-op: capture case 1, assert RST one cycle later → ACK stays 0 and DATAOUT=0. After RST release with REQ high, the result 32'h41720000 appears 3 cycles after the new capture.
- Handshake abuse: drop REQ one cycle after capture → single-cycle ACK pulse with a valid result. Operand changes after capture do not alter DATAOUT.
